// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: one-request-at-a-time bridge from a valid/ready memory
// port to an asynchronous 16-bit SRAM. Strobes are held active for
// WAIT_CYCLES cycles. A one-cycle DONE phase keeps CE, address and write
// data stable for hold time. After each write an optional TURN gap lets
// the bus settle before the next access.
module sram_access_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [15:0]       Data,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] TURN   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam bit         HAS_TURN  = (TURN_CYCLES > 0);
  localparam logic [3:0] TURN_LOAD = HAS_TURN ? 4'(TURN_CYCLES - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        be_p0;
  logic [15:0]       wdata_p0;

  logic in_access;
  logic in_done;
  logic on_bus;
  logic drive_data;

  // Byte lanes that were not enabled read back as zero.
  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] be);
    logic [15:0] r;
    r[15:8] = be[1] ? d[15:8] : 8'h00;
    r[7:0]  = be[0] ? d[7:0]  : 8'h00;
    return r;
  endfunction

  // Access sequencer: latch a request in IDLE, count wait states, then
  // DONE and an optional post-write turnaround gap.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_p0     <= 1'b0;
      addr_p0   <= '0;
      be_p0     <= 2'b00;
      wdata_p0  <= 16'h0000;
      rsp_rdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            be_p0    <= req_be;
            wdata_p0 <= req_wdata;
            cnt      <= WAIT_LOAD;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (!we_p0) rsp_rdata <= lane_mask(Data, be_p0);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (we_p0 && HAS_TURN) begin
            cnt   <= TURN_LOAD;
            state <= TURN;
          end else begin
            state <= IDLE;
          end
        end
        TURN: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM pins decode only from the registered state and latched request,
  // never from req_*.
  assign in_access  = (state == ACCESS);
  assign in_done    = (state == DONE);
  assign on_bus     = in_access | in_done;
  assign drive_data = on_bus & we_p0;

  assign CE   = ~on_bus;
  assign UB   = ~(on_bus & be_p0[1]);
  assign LB   = ~(on_bus & be_p0[0]);
  assign OE   = ~(in_access & ~we_p0);
  assign WE   = ~(in_access & we_p0);
  assign ADDR = addr_p0;
  assign Data = drive_data ? wdata_p0 : 16'hzzzz;

  assign req_ready = Reset & (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = in_done;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: three controller instances with different
// address widths, wait states and turnaround, each attached to its own
// behavioural SRAM. A transaction-level model predicts every pin cycle by
// cycle; one negedge process compares the active instance against it.
module tb_sram_access_ctrl;

  localparam int NI = 3;

  function automatic int cfg_aw(input int k);
    return (k == 0) ? 20 : 18;
  endfunction
  function automatic int cfg_wait(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction
  function automatic int cfg_turn(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 7;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a  [NI];
  logic        vld_a  [NI];
  logic        we_a   [NI];
  logic [19:0] addr_a [NI];
  logic [1:0]  be_a   [NI];
  logic [15:0] wd_a   [NI];

  logic        o_ready [NI];
  logic        o_rsp   [NI];
  logic        o_ce    [NI];
  logic        o_ub    [NI];
  logic        o_lb    [NI];
  logic        o_oe    [NI];
  logic        o_we    [NI];
  logic        o_busy  [NI];
  logic [15:0] o_rdata [NI];
  logic [15:0] o_bus   [NI];
  logic [19:0] o_addr  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int AW = cfg_aw(g);
    logic [AW-1:0] addr;
    wire  [15:0]   bus;
    logic          sram_drv;
    logic [15:0]   mem [0:(1<<AW)-1];

    sram_access_ctrl #(
      .ADDR_W(AW), .WAIT_CYCLES(cfg_wait(g)), .TURN_CYCLES(cfg_turn(g))
    ) u_dut (
      .Clk(clk), .Reset(rst_a[g]),
      .req_valid(vld_a[g]), .req_ready(o_ready[g]), .req_we(we_a[g]),
      .req_addr(addr_a[g][AW-1:0]), .req_be(be_a[g]), .req_wdata(wd_a[g]),
      .rsp_valid(o_rsp[g]), .rsp_rdata(o_rdata[g]),
      .CE(o_ce[g]), .UB(o_ub[g]), .LB(o_lb[g]), .OE(o_oe[g]), .WE(o_we[g]),
      .ADDR(addr), .Data(bus), .busy(o_busy[g])
    );

    // Asynchronous SRAM: drives the full word while read-enabled, writes
    // enabled byte lanes while WE is low.
    assign sram_drv  = !o_ce[g] && !o_oe[g] && o_we[g];
    assign bus       = sram_drv ? mem[addr] : 16'hzzzz;
    assign o_bus[g]  = bus;
    assign o_addr[g] = 20'(addr);

    always @(posedge clk) begin
      if (!o_ce[g] && !o_we[g]) begin
        if (!o_ub[g]) mem[addr][15:8] <= bus[15:8];
        if (!o_lb[g]) mem[addr][7:0]  <= bus[7:0];
      end
    end
  end

  typedef struct packed {
    logic        en, ready, rsp, ce, ub, lb, oe, we, busy, addr_en, lit_en;
    logic [19:0] addr;
    logic [15:0] bus, rdata, lit;
  } exp_t;

  exp_t        ev;
  int          cur;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] last_rdata [NI];
  logic [15:0] ref_mem [int];
  logic [19:0] pool [6];

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", nm, cur, $time, act, req);
    end
  endtask

  // Released bus: nothing drives it, and it reads as zero in this two-state
  // simulation, so any stray driver shows up as a non-zero value.
  always @(negedge clk) begin
    if (ev.en) begin
      chk("req_ready", 20'(o_ready[cur]), 20'(ev.ready));
      chk("rsp_valid", 20'(o_rsp[cur]),   20'(ev.rsp));
      chk("busy",      20'(o_busy[cur]),  20'(ev.busy));
      chk("CE",        20'(o_ce[cur]),    20'(ev.ce));
      chk("UB",        20'(o_ub[cur]),    20'(ev.ub));
      chk("LB",        20'(o_lb[cur]),    20'(ev.lb));
      chk("OE",        20'(o_oe[cur]),    20'(ev.oe));
      chk("WE",        20'(o_we[cur]),    20'(ev.we));
      chk("Data",      20'(o_bus[cur]),   20'(ev.bus));
      chk("rsp_rdata", 20'(o_rdata[cur]), 20'(ev.rdata));
      if (ev.addr_en) chk("ADDR", o_addr[cur], ev.addr);
      if (ev.lit_en)  chk("rdata_literal", 20'(o_rdata[cur]), 20'(ev.lit));
    end
  end

  function automatic int key(input int k, input logic [19:0] a);
    return (k << 20) | int'(a);
  endfunction

  function automatic logic [15:0] lanes(input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
  endfunction

  function automatic exp_t idle_exp(input int k);
    exp_t e = '0;
    e.en = 1; e.ready = 1; e.ce = 1; e.ub = 1; e.lb = 1; e.oe = 1; e.we = 1;
    e.rdata = last_rdata[k];
    return e;
  endfunction

  // Pins during busy cycle c (1-based) after acceptance: c<=W access,
  // c==W+1 done, beyond that the write turnaround gap.
  function automatic exp_t busy_exp(input int k, input int c, input logic we,
                                    input logic [19:0] a, input logic [1:0] be,
                                    input logic [15:0] wd, input logic [15:0] word);
    exp_t e = '0;
    int   w = cfg_wait(k);
    e.en = 1; e.busy = 1; e.rdata = last_rdata[k];
    e.oe = 1; e.we = 1; e.ce = 1; e.ub = 1; e.lb = 1;
    if (c <= w + 1) begin
      e.ce = 0; e.ub = ~be[1]; e.lb = ~be[0]; e.addr_en = 1; e.addr = a;
    end
    if (c <= w) begin
      e.oe  = we;
      e.we  = ~we;
      e.bus = we ? wd : word;
    end else if (c == w + 1) begin
      e.rsp = 1;
      e.bus = we ? wd : 16'h0000;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk(input int k);
    vld_a[k]  = 1'($urandom);
    we_a[k]   = 1'($urandom);
    addr_a[k] = 20'($urandom);
    be_a[k]   = 2'($urandom);
    wd_a[k]   = 16'($urandom);
  endtask

  task automatic xact(input int k, input logic we, input logic [19:0] a, input logic [1:0] be,
                      input logic [15:0] wd, input logic lit_en, input logic [15:0] lit);
    int          w      = cfg_wait(k);
    int          busy_n = w + 1 + (we ? cfg_turn(k) : 0);
    logic [19:0] am     = a & 20'((1 << cfg_aw(k)) - 1);
    logic [15:0] word;
    word = ref_mem.exists(key(k, am)) ? ref_mem[key(k, am)] : 16'h0000;
    vld_a[k] = 1; we_a[k] = we; addr_a[k] = am; be_a[k] = be; wd_a[k] = wd;
    ev = idle_exp(k);
    step();
    for (int c = 1; c <= busy_n; c++) begin
      junk(k);
      if (c == w + 1) begin
        if (we) ref_mem[key(k, am)] = {be[1] ? wd[15:8] : word[15:8], be[0] ? wd[7:0] : word[7:0]};
        else    last_rdata[k] = lanes(word, be);
      end
      ev = busy_exp(k, c, we, am, be, wd, word);
      if (c == w + 1 && !we) begin
        ev.lit_en = lit_en;
        ev.lit    = lit;
      end
      step();
    end
    vld_a[k] = 0;
  endtask

  task automatic do_reset(input int k);
    rst_a[k] = 0; vld_a[k] = 0;
    ev = '0;
    step();
    last_rdata[k] = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      ev = idle_exp(k); ev.ready = 0; ev.addr_en = 1; ev.addr = 20'h0;
      step();
    end
    rst_a[k] = 1;
    ev = idle_exp(k); ev.addr_en = 1; ev.addr = 20'h0;
    step();
  endtask

  task automatic reset_mid_write(input int k, input logic [19:0] a, input logic [15:0] wd);
    int          w  = cfg_wait(k);
    int          r  = (w >= 2) ? 2 : 1;
    logic [19:0] am = a & 20'((1 << cfg_aw(k)) - 1);
    vld_a[k] = 1; we_a[k] = 1; addr_a[k] = am; be_a[k] = 2'b11; wd_a[k] = wd;
    ev = idle_exp(k);
    step();
    for (int c = 1; c <= r; c++) begin
      junk(k);
      ev = busy_exp(k, c, 1'b1, am, 2'b11, wd, 16'h0000);
      if (c == r) rst_a[k] = 0;
      step();
    end
    rst_a[k] = 1; vld_a[k] = 0;
    last_rdata[k] = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      ev = idle_exp(k); ev.addr_en = 1; ev.addr = 20'h0;
      step();
    end
    ref_mem.delete(key(k, am));
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 0; vld_a[k] = 0; we_a[k] = 0; addr_a[k] = '0; be_a[k] = '0; wd_a[k] = '0;
      last_rdata[k] = 16'h0000;
    end
    ev  = '0;
    cur = 0;
    for (int k = 0; k < NI; k++) begin
      cur = k;
      do_reset(k);
      xact(k, 1, 20'h00123, 2'b11, 16'hBEEF, 0, 16'h0);
      xact(k, 0, 20'h00123, 2'b11, 16'h0,    1, 16'hBEEF);
      xact(k, 1, 20'h00010, 2'b11, 16'h1234, 0, 16'h0);
      xact(k, 1, 20'h00010, 2'b10, 16'hAB00, 0, 16'h0);
      xact(k, 0, 20'h00010, 2'b11, 16'h0,    1, 16'hAB34);
      xact(k, 0, 20'h00010, 2'b01, 16'h0,    1, 16'h0034);
      xact(k, 1, 20'h00123, 2'b00, 16'h5555, 0, 16'h0);
      xact(k, 0, 20'h00123, 2'b00, 16'h0,    1, 16'h0000);
      xact(k, 0, 20'h00123, 2'b11, 16'h0,    1, 16'hBEEF);
      for (int i = 0; i < 6; i++) begin
        pool[i] = (20'($urandom) | 20'h20000) & 20'hFFFFE;
        xact(k, 1, pool[i], 2'b11, 16'($urandom), 0, 16'h0);
      end
      for (int i = 0; i < 30; i++) begin
        xact(k, 1'($urandom), pool[$urandom_range(0, 5)], 2'($urandom), 16'($urandom), 0, 16'h0);
      end
      reset_mid_write(k, 20'hFFFFF, 16'hC3C3);
      xact(k, 0, pool[0], 2'b11, 16'h0, 0, 16'h0);
    end
    ev = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
